ddc_capture: RTL and testbench
==============================

Name: ddc_capture

Overview:
- Receive-side counterpart of the transmit-path up-converter.
- Accepts the down-converted I/Q AXI-Stream (32-bit {I[31:16],Q[15:0]}), already brought into the lbs_clk domain by an upstream FWFT FIFO.
- Under local-bus command, captures one frame of CAP_LEN samples into a dual-port buffer for the host to read back.
- Shares the local-bus map style of the transmit path: sample window, command register, status register.

Parameters:
U_DLY, 1, simulation delay on registered assignments
START_ADDR, 14'd12000, first local-bus address of the capture window
CAP_LEN, 3840, samples per capture (window END = START_ADDR+CAP_LEN-1 = 15839)
CMD_ADDR, 14'd16100, command register address (R/W)
STAT_ADDR, 14'd16101, status register address (RO)
FRAME_ALIGN, 1, 1 = capture starts on first beat after an s_tlast; 0 = starts on next valid beat

Ports:
rst_n  in  1  asynchronous, active-low reset
lbs_clk  in  1  clock for all logic
lbs_we  in  1  local-bus write strobe
lbs_re  in  1  local-bus read strobe
lbs_addr  in  14  local-bus address
lbs_din  in  32  local-bus write data
lbs_dout  out  32  read data, registered
lbs_dvalid  out  1  one-cycle pulse, lbs_dout valid
s_tvalid  in  1  stream valid
s_tready  out  1  stream ready
s_tdata  in  32  {I,Q} sample
s_tlast  in  1  frame boundary (256-beat frames upstream)
cap_busy  out  1  high in ARMED or CAPTURE
cap_done  out  1  level, high in DONE (host interrupt)

Behaviour:
- Reset values: lbs_dout=0, lbs_dvalid=0, cap_busy=0, cap_done=0, state=IDLE, wr_ptr=0, cmd_reg=0. s_tready=1 out of reset.
- s_tready is constantly 1. The block never back-pressures; beats outside CAPTURE are discarded.
- Commands: a write to CMD_ADDR stores lbs_din into cmd_reg (readable), then decodes:
  - ARM = 32'h5555: from IDLE or DONE -> ARMED; wr_ptr<=0; done cleared. Ignored in ARMED/CAPTURE.
  - ABORT = 32'h8888: any state -> IDLE; wr_ptr<=0.
  - FORCE = 32'hFFFF: from ARMED -> CAPTURE at once, bypassing alignment. Ignored elsewhere.
  - Any other value: stored only, no action.
- Command decode is registered: state acts one cycle after the write cycle.
- FSM:
  - IDLE: discard beats.
  - ARMED: if FRAME_ALIGN=1, a beat with s_tvalid&s_tlast sets aligned; the next valid beat is written and the state goes to CAPTURE. If FRAME_ALIGN=0, the first valid beat is written and the state goes to CAPTURE.
  - CAPTURE: each s_tvalid beat writes RAM[wr_ptr] and increments wr_ptr. The write at wr_ptr==CAP_LEN-1 -> DONE; wr_ptr holds at CAP_LEN.
  - DONE: discard beats; hold until ARM or ABORT.
- Boundaries:
  - The captured beat on ARMED->CAPTURE is sample 0 (no loss).
  - s_tvalid gaps simply pause capture.
  - Stream tlast inside CAPTURE is ignored.
  - A command write in the same cycle as the final capture beat: the beat is written and DONE is reached. The registered command then acts on DONE: ABORT -> IDLE, ARM -> re-arm.
  - Async reset mid-capture: immediate IDLE; RAM contents are retained but undefined to the host.
- Buffer: simple dual-port, CAP_LEN x 32.
  - Port A write: stream side.
  - Port B read: bus side, address lbs_addr-START_ADDR, 1-cycle read.
- Reads:
  - lbs_re with address in [START_ADDR, END]: lbs_dout = RAM word; lbs_dvalid pulses 2 cycles after lbs_re.
  - CMD_ADDR -> cmd_reg; STAT_ADDR -> status. Both use the same 2-cycle latency.
  - Unmapped addresses return 0 with dvalid.
  - Reads during CAPTURE are permitted and return current RAM content.
  - Back-to-back lbs_re is supported, one per cycle, in order.
- Status word: [31] done, [30] busy, [29] aligned, [28] beats_dropped_in_done (sticky, cleared by ARM), [27:24] state code (IDLE 0, ARMED 1, CAPTURE 2, DONE 3), [11:0] wr_ptr.
- cap_busy and cap_done are decoded from the registered state, with no extra latency.

Decomposition:
- Package ddc_capture_pkg: state enum and codes; command constants CMD_ARM, CMD_ABORT, CMD_FORCE; status bit positions.
- The address constants stay as parameters.
- One sub-module, cap_sdpram: inferred simple dual-port RAM, parameterised depth/width, 1-cycle registered read. Everything else is flat in ddc_capture.

Test Plan:
- Reset, read STAT_ADDR -> 32'h0000_0000, dvalid 2 cycles after re; s_tready=1.
- FRAME_ALIGN=1, ARM, stream counter data with tlast every 256 beats -> RAM[0] equals the beat after the first tlast. RAM[3839] = RAM[0]+3839. cap_done=1, status wr_ptr=3840, beats after DONE set bit 28.
- ARM then FORCE with s_tvalid toggling 50% -> capture begins next valid beat; 3840 words contiguous, no gaps or duplicates.
- ABORT mid-capture at wr_ptr=100 -> state IDLE, busy=0, done=0. Re-ARM captures a fresh frame from index 0.
- ABORT written in same cycle as the final beat -> state IDLE after one cycle, cap_done low afterwards. ARM in DONE clears done and bit 28.
- Read burst of 16 consecutive window addresses plus CMD_ADDR during CAPTURE -> 17 dvalid pulses in order; cmd readback 32'h5555.

Source files
------------

// File: rtl/ddc_capture_pkg.sv
// Shared types and constants for the receive capture block: FSM states, host command words, status layout.
// No logic here.
package ddc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // Decoded form of the last command write, held for exactly one cycle.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_ARM,
        OP_ABORT,
        OP_FORCE
    } cmd_op_t;

    localparam logic [31:0] CMD_ARM   = 32'h0000_5555;
    localparam logic [31:0] CMD_ABORT = 32'h0000_8888;
    localparam logic [31:0] CMD_FORCE = 32'h0000_FFFF;

    localparam int STAT_DONE_BIT  = 31;
    localparam int STAT_BUSY_BIT  = 30;
    localparam int STAT_ALIGN_BIT = 29;
    localparam int STAT_DROP_BIT  = 28;
    localparam int STAT_CODE_LSB  = 24;
    localparam int STAT_PTR_W     = 12;

    function automatic cmd_op_t decode_cmd(input logic [31:0] word);
        cmd_op_t op;
        op = OP_NONE;
        if (word == CMD_ARM)        op = OP_ARM;
        else if (word == CMD_ABORT) op = OP_ABORT;
        else if (word == CMD_FORCE) op = OP_FORCE;
        return op;
    endfunction

    function automatic logic [31:0] pack_status(input logic done, input logic busy,
                                                input logic aligned, input logic dropped,
                                                input cap_state_t st,
                                                input logic [STAT_PTR_W-1:0] ptr);
        logic [31:0] s;
        s = '0;
        s[STAT_DONE_BIT]            = done;
        s[STAT_BUSY_BIT]            = busy;
        s[STAT_ALIGN_BIT]           = aligned;
        s[STAT_DROP_BIT]            = dropped;
        s[STAT_CODE_LSB +: 4]       = {2'b00, st};
        s[STAT_PTR_W-1:0]           = ptr;
        return s;
    endfunction

endpackage

// File: rtl/cap_sdpram.sv
// Simple dual-port RAM: one write port, one read port with a registered 1-cycle read.
// Latency 1 cycle on read; no backpressure, both ports accept every cycle.
module cap_sdpram #(
    parameter int DEPTH = 3840,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset: contents survive a reset and are simply stale to the host.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/ddc_capture.sv
// Captures one frame of down-converted I/Q samples into a host-readable buffer under local-bus command.
// Bus reads return 2 cycles after lbs_re; the stream is never back-pressured (beats outside capture are dropped).
module ddc_capture
    import ddc_capture_pkg::*;
#(
    parameter logic [13:0] START_ADDR  = 14'd12000,
    parameter int          CAP_LEN     = 3840,
    parameter logic [13:0] CMD_ADDR    = 14'd16100,
    parameter logic [13:0] STAT_ADDR   = 14'd16101,
    parameter int          FRAME_ALIGN = 1
) (
    input  logic        rst_n,
    input  logic        lbs_clk,
    input  logic        lbs_we,
    input  logic        lbs_re,
    input  logic [13:0] lbs_addr,
    input  logic [31:0] lbs_din,
    output logic [31:0] lbs_dout,
    output logic        lbs_dvalid,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [31:0] s_tdata,
    input  logic        s_tlast,
    output logic        cap_busy,
    output logic        cap_done
);

    localparam int              AW       = $clog2(CAP_LEN);
    localparam int              PW       = $clog2(CAP_LEN + 1);
    localparam logic [13:0]     END_ADDR = START_ADDR + 14'(CAP_LEN - 1);
    localparam logic [PW-1:0]   LAST_PTR = PW'(CAP_LEN - 1);

    cap_state_t     state_q;
    logic [PW-1:0]  wr_ptr_q;
    logic           aligned_q;
    logic           dropped_q;
    logic [31:0]    cmd_reg_q;
    cmd_op_t        cmd_op_q;

    logic           abort_now;
    logic           arm_now;
    logic           force_now;
    logic           beat_take;

    logic           in_win;
    logic [31:0]    status_w;
    logic [31:0]    rd_reg_d;
    logic [31:0]    rd_dat_d;
    logic [31:0]    ram_rdata;
    logic           rd_vld_q;
    logic           rd_win_q;
    logic [31:0]    rd_reg_q;
    logic [31:0]    lbs_dout_q;
    logic           lbs_dvalid_q;

    assign s_tready   = 1'b1;
    assign cap_busy   = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign cap_done   = (state_q == ST_DONE);
    assign lbs_dout   = lbs_dout_q;
    assign lbs_dvalid = lbs_dvalid_q;

    always_comb begin
        abort_now = (cmd_op_q == OP_ABORT);
        arm_now   = (cmd_op_q == OP_ARM) && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        force_now = (cmd_op_q == OP_FORCE) && (state_q == ST_ARMED);
        // An ABORT acting this cycle wins over a coincident beat.
        beat_take = s_tvalid && !abort_now &&
                    ((state_q == ST_CAPTURE) ||
                     ((state_q == ST_ARMED) && ((FRAME_ALIGN == 0) || aligned_q)));
    end

    // Command register; the decoded op is applied by the FSM on the following cycle.
    always_ff @(posedge lbs_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg_q <= '0;
            cmd_op_q  <= OP_NONE;
        end else if (lbs_we && (lbs_addr == CMD_ADDR)) begin
            cmd_reg_q <= lbs_din;
            cmd_op_q  <= decode_cmd(lbs_din);
        end else begin
            cmd_op_q  <= OP_NONE;
        end
    end

    always_ff @(posedge lbs_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            aligned_q <= 1'b0;
            dropped_q <= 1'b0;
        end else if (abort_now) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            aligned_q <= 1'b0;
        end else if (arm_now) begin
            state_q   <= ST_ARMED;
            wr_ptr_q  <= '0;
            aligned_q <= 1'b0;
            dropped_q <= 1'b0;
        end else if (beat_take) begin
            // The beat that leaves ARMED is sample 0, so both states share this path.
            wr_ptr_q <= wr_ptr_q + 1'b1;
            state_q  <= (wr_ptr_q == LAST_PTR) ? ST_DONE : ST_CAPTURE;
        end else if (force_now) begin
            state_q  <= ST_CAPTURE;
        end else if ((state_q == ST_ARMED) && (FRAME_ALIGN != 0) && s_tvalid && s_tlast) begin
            aligned_q <= 1'b1;
        end else if ((state_q == ST_DONE) && s_tvalid) begin
            dropped_q <= 1'b1;
        end
    end

    cap_sdpram #(
        .DEPTH (CAP_LEN),
        .WIDTH (32),
        .AW    (AW)
    ) u_ram (
        .clk_i   (lbs_clk),
        .we_i    (beat_take),
        .waddr_i (AW'(wr_ptr_q)),
        .wdata_i (s_tdata),
        .re_i    (lbs_re && in_win),
        .raddr_i (AW'(lbs_addr - START_ADDR)),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        in_win   = (lbs_addr >= START_ADDR) && (lbs_addr <= END_ADDR);
        status_w = pack_status(cap_done, cap_busy, aligned_q, dropped_q, state_q,
                               STAT_PTR_W'(wr_ptr_q));
        rd_reg_d = '0;
        if (lbs_addr == CMD_ADDR) begin
            rd_reg_d = cmd_reg_q;
        end else if (lbs_addr == STAT_ADDR) begin
            rd_reg_d = status_w;
        end
        rd_dat_d = rd_win_q ? ram_rdata : rd_reg_q;
    end

    // Register reads are snapshotted in stage 1 so they line up with the RAM read.
    always_ff @(posedge lbs_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q     <= 1'b0;
            rd_win_q     <= 1'b0;
            rd_reg_q     <= '0;
            lbs_dout_q   <= '0;
            lbs_dvalid_q <= 1'b0;
        end else begin
            rd_vld_q     <= lbs_re;
            rd_win_q     <= lbs_re && in_win;
            if (lbs_re) begin
                rd_reg_q <= rd_reg_d;
            end
            lbs_dvalid_q <= rd_vld_q;
            if (rd_vld_q) begin
                lbs_dout_q <= rd_dat_d;
            end
        end
    end

endmodule

// File: tb/tb_ddc_capture.sv
// Bench for ddc_capture: bus reads are scored against a queue of expected words and return cycles.
module tb_ddc_capture;

    localparam logic [13:0] A_WIN  = 14'd12000;
    localparam logic [13:0] A_CMD  = 14'd16100;
    localparam logic [13:0] A_STAT = 14'd16101;
    localparam int          N_CAP  = 3840;
    localparam logic [31:0] NO_AL  = 32'hDFFF_FFFF;
    localparam logic [31:0] ALL    = 32'hFFFF_FFFF;

    logic        rst_n;
    logic        lbs_clk;
    logic        lbs_we;
    logic        lbs_re;
    logic [13:0] lbs_addr;
    logic [31:0] lbs_din;
    logic [31:0] lbs_dout;
    logic        lbs_dvalid;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        cap_busy;
    logic        cap_done;

    typedef struct {
        logic [31:0] dat;
        logic [31:0] msk;
        int          cyc;
        logic [13:0] addr;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      errors   = 0;
    int      checks   = 0;
    int      cyc      = 0;
    int      dv_count = 0;

    ddc_capture dut (
        .rst_n      (rst_n),
        .lbs_clk    (lbs_clk),
        .lbs_we     (lbs_we),
        .lbs_re     (lbs_re),
        .lbs_addr   (lbs_addr),
        .lbs_din    (lbs_din),
        .lbs_dout   (lbs_dout),
        .lbs_dvalid (lbs_dvalid),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .cap_busy   (cap_busy),
        .cap_done   (cap_done)
    );

    initial lbs_clk = 1'b0;
    always #5 lbs_clk = ~lbs_clk;

    always @(posedge lbs_clk) cyc <= cyc + 1;

    // Scoreboard: every dvalid pops the oldest outstanding read.
    always @(negedge lbs_clk) begin
        if (lbs_dvalid === 1'b1) begin
            rd_exp_t e;
            dv_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: dvalid at cycle %0d with no read pending, dout=%h", cyc, lbs_dout);
            end else begin
                e = exp_q.pop_front();
                if (((lbs_dout & e.msk) !== (e.dat & e.msk)) || (cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL rd_%0d: dout=%h at cycle %0d, want %h (mask %h) at cycle %0d",
                             e.addr, lbs_dout, cyc, e.dat, e.msk, e.cyc);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
        @(negedge lbs_clk);
        lbs_we = 1'b1; lbs_re = 1'b0; lbs_addr = a; lbs_din = d;
    endtask

    task automatic bus_read(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        rd_exp_t e;
        @(negedge lbs_clk);
        lbs_re = 1'b1; lbs_we = 1'b0; lbs_addr = a;
        e.dat = d; e.msk = m; e.cyc = cyc + 2; e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic bus_idle();
        @(negedge lbs_clk);
        lbs_re = 1'b0; lbs_we = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge lbs_clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_drain: %0d reads still outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Drives nvalid valid beats of base+index; optionally writes a command alongside the last beat.
    task automatic stream_beats(input int nvalid, input logic [31:0] base, input bit gaps,
                                input bit tlasts, input bit cmd_last, input logic [31:0] cmd);
        int sent = 0;
        while (sent < nvalid) begin
            @(negedge lbs_clk);
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                s_tvalid = 1'b0; s_tlast = 1'b0;
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = base + 32'(sent);
                s_tlast  = tlasts && ((sent % 256) == 255);
                if (cmd_last && (sent == nvalid - 1)) begin
                    lbs_we = 1'b1; lbs_addr = A_CMD; lbs_din = cmd;
                end
                sent++;
            end
        end
        @(negedge lbs_clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        if (cmd_last) lbs_we = 1'b0;
    endtask

    task automatic read_frame(input logic [31:0] base);
        for (int k = 0; k < N_CAP; k++) begin
            bus_read(14'(A_WIN + 14'(k)), base + 32'(k), ALL);
        end
        bus_idle();
        wait_drain();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge lbs_clk);
        checks += 5;
        if (lbs_dout !== 32'h0)  begin errors++; $display("FAIL rst_dout: got %h want 0", lbs_dout); end
        if (lbs_dvalid !== 1'b0) begin errors++; $display("FAIL rst_dvalid: got %b want 0", lbs_dvalid); end
        if (cap_busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b want 0", cap_busy); end
        if (cap_done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b want 0", cap_done); end
        if (s_tready !== 1'b1)   begin errors++; $display("FAIL rst_tready: got %b want 1", s_tready); end
        rst_n = 1'b1;
        bus_read(A_STAT, 32'h0, ALL);
        bus_read(A_CMD, 32'h0, ALL);
        bus_write(A_CMD, 32'h0000_1234);
        bus_read(A_CMD, 32'h0000_1234, ALL);
        bus_read(14'd0, 32'h0, ALL);
        bus_read(14'd16102, 32'h0, ALL);
        bus_read(A_STAT, 32'h0, ALL);
        bus_idle();
        wait_drain();
        checks++;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL idle_tready: got %b want 1", s_tready); end
    endtask

    task automatic test_align_capture();
        bus_write(A_CMD, 32'h0000_5555);
        bus_idle();
        // tlast on beat 255, so beat 256 is sample 0; the last four beats land in DONE.
        stream_beats(4100, 32'h1000_0000, 1'b0, 1'b1, 1'b0, 32'h0);
        checks += 2;
        if (cap_done !== 1'b1) begin errors++; $display("FAIL align_done: got %b want 1", cap_done); end
        if (cap_busy !== 1'b0) begin errors++; $display("FAIL align_busy: got %b want 0", cap_busy); end
        bus_read(A_STAT, 32'hB300_0F00, NO_AL);
        bus_idle();
        wait_drain();
        read_frame(32'h1000_0100);
    endtask

    task automatic test_force_gaps();
        bus_write(A_CMD, 32'h0000_5555);
        bus_idle();
        bus_read(A_STAT, 32'h4100_0000, NO_AL);
        checks += 2;
        if (cap_done !== 1'b0) begin errors++; $display("FAIL rearm_done: got %b want 0", cap_done); end
        if (cap_busy !== 1'b1) begin errors++; $display("FAIL rearm_busy: got %b want 1", cap_busy); end
        bus_write(A_CMD, 32'h0000_FFFF);
        bus_read(A_STAT, 32'h4100_0000, NO_AL);
        bus_read(A_STAT, 32'h4200_0000, NO_AL);
        bus_idle();
        stream_beats(N_CAP, 32'h2000_0000, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (cap_done !== 1'b1) begin errors++; $display("FAIL force_done: got %b want 1", cap_done); end
        bus_read(A_STAT, 32'h8300_0F00, NO_AL);
        bus_idle();
        wait_drain();
        read_frame(32'h2000_0000);
    endtask

    task automatic test_abort();
        bus_write(A_CMD, 32'h0000_5555);
        bus_write(A_CMD, 32'h0000_FFFF);
        bus_idle();
        stream_beats(100, 32'h3000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
        bus_read(A_STAT, 32'h4200_0064, NO_AL);
        bus_write(A_CMD, 32'h0000_8888);
        bus_idle();
        @(negedge lbs_clk);
        checks += 2;
        if (cap_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", cap_busy); end
        if (cap_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", cap_done); end
        bus_read(A_STAT, 32'h0000_0000, NO_AL);
        bus_idle();
        wait_drain();
        bus_write(A_CMD, 32'h0000_5555);
        bus_write(A_CMD, 32'h0000_FFFF);
        bus_idle();
        stream_beats(N_CAP, 32'h5000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_8888);
        checks++;
        if (cap_done !== 1'b1) begin errors++; $display("FAIL final_done: got %b want 1", cap_done); end
        @(negedge lbs_clk);
        checks += 2;
        if (cap_done !== 1'b0) begin errors++; $display("FAIL final_abort_done: got %b want 0", cap_done); end
        if (cap_busy !== 1'b0) begin errors++; $display("FAIL final_abort_busy: got %b want 0", cap_busy); end
        bus_read(A_STAT, 32'h0000_0000, NO_AL);
        bus_read(A_WIN, 32'h5000_0000, ALL);
        bus_read(14'(A_WIN + 14'd1), 32'h5000_0001, ALL);
        bus_read(14'(A_WIN + 14'd99), 32'h5000_0063, ALL);
        bus_read(14'(A_WIN + 14'd100), 32'h5000_0064, ALL);
        bus_read(14'(A_WIN + 14'd3839), 32'h5000_0EFF, ALL);
        bus_idle();
        wait_drain();
    endtask

    task automatic test_read_burst();
        int dvc0;
        bus_write(A_CMD, 32'h0000_5555);
        bus_idle();
        dvc0 = dv_count;
        fork
            stream_beats(600, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 32'h0);
            begin
                repeat (320) @(negedge lbs_clk);
                for (int k = 0; k < 16; k++) begin
                    bus_read(14'(A_WIN + 14'(k)), 32'h4000_0100 + 32'(k), ALL);
                end
                bus_read(A_CMD, 32'h0000_5555, ALL);
                bus_idle();
            end
        join
        wait_drain();
        checks++;
        if ((dv_count - dvc0) != 17) begin
            errors++;
            $display("FAIL burst_count: got %0d dvalid pulses want 17", dv_count - dvc0);
        end
        bus_read(A_STAT, 32'h4200_0158, NO_AL);
        bus_idle();
        wait_drain();
    endtask

    task automatic test_async_reset();
        @(negedge lbs_clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (cap_busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", cap_busy); end
        if (cap_done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", cap_done); end
        @(negedge lbs_clk);
        rst_n = 1'b1;
        bus_read(A_STAT, 32'h0, ALL);
        bus_read(A_CMD, 32'h0, ALL);
        bus_idle();
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0; lbs_we = 1'b0; lbs_re = 1'b0; lbs_addr = '0; lbs_din = '0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        test_reset();
        test_align_capture();
        test_force_gaps();
        test_abort();
        test_read_burst();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
